// File: rtl/match_sequencer_if.sv
// Handshake bundle between the match sequencer and its surroundings (buttons, game_controller, vga).
// master drives the button/score levels; slave is the sequencer. MATCH_PAUSE_EN adds pause_button.
interface match_sequencer_if;
  logic       start_button;
  logic       team1_score;
  logic       team2_score;
`ifdef MATCH_PAUSE_EN
  logic       pause_button;
`endif
  logic       game_run;
  logic       ball_reset;
  logic [3:0] team1_points;
  logic [3:0] team2_points;
  logic [1:0] winner;
  logic       flash;
  logic [2:0] state;

  modport master (
`ifdef MATCH_PAUSE_EN
    output pause_button,
`endif
    output start_button, team1_score, team2_score,
    input  game_run, ball_reset, team1_points, team2_points, winner, flash, state
  );

  modport slave (
`ifdef MATCH_PAUSE_EN
    input  pause_button,
`endif
    input  start_button, team1_score, team2_score,
    output game_run, ball_reset, team1_points, team2_points, winner, flash, state
  );
endinterface

// File: rtl/match_sequencer.sv
// Match-level FSM: serve, play, goal celebration and game over, with per-team points and flash strobe.
// Optional MATCH_PAUSE_EN adds pause_button and the PAUSED state (ball frozen in place).
module match_sequencer #(
  parameter int unsigned WIN_SCORE    = 5,
  parameter int unsigned SERVE_DELAY  = 50_000_000,
  parameter int unsigned GOAL_HOLD    = 100_000_000,
  parameter int unsigned FLASH_PERIOD = 12_500_000,
  parameter int unsigned CNT_W        = 27
) (
  input  logic             clk,
  input  logic             rst,
  match_sequencer_if.slave bus
);
  localparam int unsigned PTS_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_GOAL   = 3'd3,
    ST_OVER   = 3'd4,
    ST_PAUSED = 3'd5
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] timer_q;
  logic [CNT_W-1:0] flash_cnt_q;
  logic [PTS_W-1:0] team1_points_q;
  logic [PTS_W-1:0] team2_points_q;
  logic [1:0]       winner_q;
  logic             game_run_q;
  logic             ball_reset_q;
  logic             flash_q;
  logic             start_q, start_prev_q;
  logic             team1_q, team1_prev_q;
  logic             team2_q, team2_prev_q;

  logic start_edge_c, goal1_edge_c, goal2_edge_c, pause_edge_c;
  logic serve_done_c, goal_done_c, flash_tick_c, win1_c, win2_c;

  // Single input register stage plus previous-value register for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      team1_q      <= 1'b0;
      team1_prev_q <= 1'b0;
      team2_q      <= 1'b0;
      team2_prev_q <= 1'b0;
    end else begin
      start_q      <= bus.start_button;
      start_prev_q <= start_q;
      team1_q      <= bus.team1_score;
      team1_prev_q <= team1_q;
      team2_q      <= bus.team2_score;
      team2_prev_q <= team2_q;
    end
  end

`ifdef MATCH_PAUSE_EN
  logic pause_q, pause_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pause_q      <= 1'b0;
      pause_prev_q <= 1'b0;
    end else begin
      pause_q      <= bus.pause_button;
      pause_prev_q <= pause_q;
    end
  end

  assign pause_edge_c = pause_q & ~pause_prev_q;
`else
  assign pause_edge_c = 1'b0;
`endif

  assign start_edge_c = start_q & ~start_prev_q;
  assign goal1_edge_c = team1_q & ~team1_prev_q;
  assign goal2_edge_c = team2_q & ~team2_prev_q;
  assign serve_done_c = (timer_q == CNT_W'(SERVE_DELAY - 1));
  assign goal_done_c  = (timer_q == CNT_W'(GOAL_HOLD - 1));
  assign flash_tick_c = (flash_cnt_q == CNT_W'(FLASH_PERIOD - 1));
  assign win1_c       = (team1_points_q == PTS_W'(WIN_SCORE));
  assign win2_c       = (team2_points_q == PTS_W'(WIN_SCORE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      flash_cnt_q    <= '0;
      team1_points_q <= '0;
      team2_points_q <= '0;
      winner_q       <= 2'b00;
      game_run_q     <= 1'b0;
      ball_reset_q   <= 1'b1;
      flash_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_edge_c) begin
            state_q        <= ST_SERVE;
            timer_q        <= '0;
            team1_points_q <= '0;
            team2_points_q <= '0;
            winner_q       <= 2'b00;
          end
        end
        ST_SERVE: begin
          if (serve_done_c) begin
            state_q      <= ST_PLAY;
            timer_q      <= '0;
            game_run_q   <= 1'b1;
            ball_reset_q <= 1'b0;
          end else begin
            timer_q <= timer_q + CNT_W'(1);
          end
        end
        ST_PLAY: begin
          // Simultaneous goals cancel out; pause wins over a coincident goal
          if (pause_edge_c) begin
            state_q    <= ST_PAUSED;
            game_run_q <= 1'b0;
          end else if (goal1_edge_c ^ goal2_edge_c) begin
            if (goal1_edge_c) team1_points_q <= team1_points_q + PTS_W'(1);
            else              team2_points_q <= team2_points_q + PTS_W'(1);
            state_q      <= ST_GOAL;
            timer_q      <= '0;
            flash_cnt_q  <= '0;
            flash_q      <= 1'b0;
            game_run_q   <= 1'b0;
            ball_reset_q <= 1'b1;
          end
        end
        ST_PAUSED: begin
          if (pause_edge_c) begin
            state_q    <= ST_PLAY;
            game_run_q <= 1'b1;
          end
        end
        ST_GOAL: begin
          if (goal_done_c) begin
            timer_q     <= '0;
            flash_cnt_q <= '0;
            flash_q     <= 1'b0;
            if (win1_c || win2_c) begin
              state_q  <= ST_OVER;
              winner_q <= win1_c ? 2'b01 : 2'b10;
            end else begin
              state_q <= ST_SERVE;
            end
          end else begin
            timer_q     <= timer_q + CNT_W'(1);
            flash_cnt_q <= flash_tick_c ? '0 : flash_cnt_q + CNT_W'(1);
            if (flash_tick_c) flash_q <= ~flash_q;
          end
        end
        ST_OVER: begin
          if (start_edge_c) begin
            state_q        <= ST_SERVE;
            timer_q        <= '0;
            flash_cnt_q    <= '0;
            flash_q        <= 1'b0;
            team1_points_q <= '0;
            team2_points_q <= '0;
            winner_q       <= 2'b00;
          end else begin
            flash_cnt_q <= flash_tick_c ? '0 : flash_cnt_q + CNT_W'(1);
            if (flash_tick_c) flash_q <= ~flash_q;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          timer_q      <= '0;
          game_run_q   <= 1'b0;
          ball_reset_q <= 1'b1;
          flash_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state        = state_q;
  assign bus.game_run     = game_run_q;
  assign bus.ball_reset   = ball_reset_q;
  assign bus.team1_points = team1_points_q;
  assign bus.team2_points = team2_points_q;
  assign bus.winner       = winner_q;
  assign bus.flash        = flash_q;
endmodule

// File: tb/tb_match_sequencer.sv
// Randomized bench for match_sequencer: a phase/age reference model queues expected outputs per cycle,
// and an independent monitor pops and compares them after every clock edge.
module tb_match_sequencer;
  localparam int WIN_SCORE    = 3;
  localparam int SERVE_DELAY  = 4;
  localparam int GOAL_HOLD    = 6;
  localparam int FLASH_PERIOD = 2;
  localparam int NCYC         = 4000;

  localparam int PH_IDLE = 0, PH_SERVE = 1, PH_PLAY = 2, PH_GOAL = 3, PH_OVER = 4, PH_PAUSED = 5;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] p1;
    logic [3:0] p2;
    logic [1:0] w;
    logic       run;
    logic       br;
    logic       fl;
  } snap_t;

  logic clk = 1'b0;
  logic rst;

  match_sequencer_if bus ();

  match_sequencer #(
    .WIN_SCORE   (WIN_SCORE),
    .SERVE_DELAY (SERVE_DELAY),
    .GOAL_HOLD   (GOAL_HOLD),
    .FLASH_PERIOD(FLASH_PERIOD),
    .CNT_W       (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  snap_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    overs  = 0;

  // Reference model: phase, cycles spent in phase, points and winner
  int m_phase, m_age, m_p1, m_p2, m_w;
  bit ms_q, ms_p, m1_q, m1_p, m2_q, m2_p, mp_q, mp_p;

  task automatic enter(input int ph);
    m_phase = ph;
    m_age   = 0;
  endtask

  task automatic model_step(input bit r, input bit s_in, input bit t1_in, input bit t2_in, input bit p_in);
    bit    se, e1, e2, pe;
    snap_t s;
    if (r) begin
      enter(PH_IDLE);
      m_p1 = 0; m_p2 = 0; m_w = 0;
      ms_q = 0; ms_p = 0; m1_q = 0; m1_p = 0; m2_q = 0; m2_p = 0; mp_q = 0; mp_p = 0;
    end else begin
      se = ms_q && !ms_p;
      e1 = m1_q && !m1_p;
      e2 = m2_q && !m2_p;
      pe = mp_q && !mp_p;
      ms_p = ms_q; ms_q = s_in;
      m1_p = m1_q; m1_q = t1_in;
      m2_p = m2_q; m2_q = t2_in;
      mp_p = mp_q; mp_q = p_in;
      case (m_phase)
        PH_IDLE: if (se) begin enter(PH_SERVE); m_p1 = 0; m_p2 = 0; m_w = 0; end
        PH_SERVE: if (m_age + 1 == SERVE_DELAY) enter(PH_PLAY); else m_age++;
        PH_PLAY: begin
          if (pe) enter(PH_PAUSED);
          else if (e1 != e2) begin
            if (e1) m_p1++; else m_p2++;
            enter(PH_GOAL);
          end
        end
        PH_PAUSED: if (pe) enter(PH_PLAY);
        PH_GOAL: begin
          if (m_age + 1 == GOAL_HOLD) begin
            if (m_p1 == WIN_SCORE || m_p2 == WIN_SCORE) begin
              m_w = (m_p1 == WIN_SCORE) ? 1 : 2;
              enter(PH_OVER);
              overs++;
            end else enter(PH_SERVE);
          end else m_age++;
        end
        PH_OVER: if (se) begin enter(PH_SERVE); m_p1 = 0; m_p2 = 0; m_w = 0; end else m_age++;
        default: enter(PH_IDLE);
      endcase
    end
    s.st  = 3'(m_phase);
    s.p1  = 4'(m_p1);
    s.p2  = 4'(m_p2);
    s.w   = 2'(m_w);
    s.run = (m_phase == PH_PLAY);
    s.br  = !(m_phase == PH_PLAY || m_phase == PH_PAUSED);
    s.fl  = (m_phase == PH_GOAL || m_phase == PH_OVER) && (((m_age / FLASH_PERIOD) % 2) == 1);
    exp_q.push_back(s);
  endtask

  // Monitor: one expected snapshot per clock edge
  snap_t act, ex;
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      ex         = exp_q.pop_front();
      act.st     = bus.state;
      act.p1     = bus.team1_points;
      act.p2     = bus.team2_points;
      act.w      = bus.winner;
      act.run    = bus.game_run;
      act.br     = bus.ball_reset;
      act.fl     = bus.flash;
      checks++;
      if (act !== ex) begin
        errors++;
        $display("FAIL outputs t=%0t: got state=%0d p1=%0d p2=%0d winner=%b run=%b ball_reset=%b flash=%b, expected state=%0d p1=%0d p2=%0d winner=%b run=%b ball_reset=%b flash=%b",
                 $time, act.st, act.p1, act.p2, act.w, act.run, act.br, act.fl,
                 ex.st, ex.p1, ex.p2, ex.w, ex.run, ex.br, ex.fl);
      end
    end
  end

  bit s_lvl, t1_lvl, t2_lvl, p_lvl;

  initial begin
    rst = 1'b1;
    s_lvl = 0; t1_lvl = 0; t2_lvl = 0; p_lvl = 0;
    bus.start_button = 1'b0;
    bus.team1_score  = 1'b0;
    bus.team2_score  = 1'b0;
`ifdef MATCH_PAUSE_EN
    bus.pause_button = 1'b0;
`endif
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        rst = (cyc < 2) || ($urandom_range(0, 399) == 0) ||
              (m_phase == PH_GOAL && m_age == 2 && $urandom_range(0, 19) == 0);
        if ($urandom_range(0, 15) == 0) s_lvl = !s_lvl;
        if (!t1_lvl && !t2_lvl && $urandom_range(0, 29) == 0) begin
          t1_lvl = 1; t2_lvl = 1;
        end else begin
          if ($urandom_range(0, 5) == 0) t1_lvl = !t1_lvl;
          if ($urandom_range(0, 5) == 0) t2_lvl = !t2_lvl;
        end
`ifdef MATCH_PAUSE_EN
        if ($urandom_range(0, 24) == 0) p_lvl = !p_lvl;
        bus.pause_button = p_lvl;
`endif
        bus.start_button = s_lvl;
        bus.team1_score  = t1_lvl;
        bus.team2_score  = t2_lvl;
      end
      model_step(rst, s_lvl, t1_lvl, t2_lvl, p_lvl);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked snapshots, expected 0", exp_q.size());
    end
    $display("Info: matches reaching game over in model = %0d", overs);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
